// File: rtl/calc_pkg.sv
// calc_pkg: shared constants for the calculator key engine.
//   - key codes for operators, equals and clear (digits are codes 0..9)
//   - FSM state encoding
//   - operator encoding as shown on op_pend
//   - small helpers to classify a key index
package calc_pkg;

    localparam logic [4:0] KEY_ADD = 5'd10;
    localparam logic [4:0] KEY_SUB = 5'd11;
    localparam logic [4:0] KEY_MUL = 5'd12;
    localparam logic [4:0] KEY_EQ  = 5'd13;
    localparam logic [4:0] KEY_CLR = 5'd14;

    localparam logic [2:0] S_A   = 3'd0;
    localparam logic [2:0] S_OP  = 3'd1;
    localparam logic [2:0] S_B   = 3'd2;
    localparam logic [2:0] S_RES = 3'd3;
    localparam logic [2:0] S_ERR = 3'd4;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;
    localparam logic [1:0] OP_MUL  = 2'd3;

    function automatic logic is_digit(input logic [4:0] k);
        return k <= 5'd9;
    endfunction

    // Operator keys 10/11/12 map onto operator codes 1/2/3.
    function automatic logic [1:0] key_to_op(input logic [4:0] k);
        logic [4:0] t;
        t = k - 5'd9;
        return t[1:0];
    endfunction

endpackage

// File: rtl/calc_key_engine_if.sv
// calc_key_engine_if: key input and display output bundle of the key engine.
//   click     : left-button level
//   key_idx   : key under the cursor, valid while click is high
//   disp_val  : signed value to display
//   disp_err  : overflow indicator
//   op_pend   : pending operator (0 none, 1 add, 2 sub, 3 mul)
//   key_ack   : one-cycle pulse per accepted key event
// master drives the keys (decoder side), slave is the key engine.
interface calc_key_engine_if #(parameter int WIDTH = 16);
    logic                    click;
    logic [4:0]              key_idx;
    logic signed [WIDTH-1:0] disp_val;
    logic                    disp_err;
    logic [1:0]              op_pend;
    logic                    key_ack;

    modport master (
        output click, key_idx,
        input  disp_val, disp_err, op_pend, key_ack
    );

    modport slave (
        input  click, key_idx,
        output disp_val, disp_err, op_pend, key_ack
    );
endinterface

// File: rtl/calc_alu.sv
// calc_alu: combinational evaluator R = A op B at double width.
//   a, b : signed operands (WIDTH bits)
//   op   : operator code (calc_pkg OP_*)
//   r    : low WIDTH bits of the result
//   ovf  : |R| exceeds the largest DIGITS-digit decimal value
// Optional feature macro: CALC_MUL_EN adds the multiply path; without it
// the multiply code falls through to "pass A" and no multiplier exists.
module calc_alu
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 16
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic [1:0]              op,
    output logic signed [WIDTH-1:0] r,
    output logic                    ovf
);
    localparam int WW = 2 * WIDTH;
    localparam logic signed [WW-1:0] LIMIT = WW'(10 ** DIGITS - 1);

    logic signed [WW-1:0] wa;
    logic signed [WW-1:0] wb;
    logic signed [WW-1:0] wr;

    assign wa = {{WIDTH{a[WIDTH-1]}}, a};
    assign wb = {{WIDTH{b[WIDTH-1]}}, b};

    always_comb begin
        wr = wa;
        case (op)
            OP_ADD:  wr = wa + wb;
            OP_SUB:  wr = wa - wb;
`ifdef CALC_MUL_EN
            OP_MUL:  wr = wa * wb;
`endif
            default: wr = wa;
        endcase
    end

    // Range check on the full-width result so a wrapped low half can never
    // masquerade as an in-range value.
    assign ovf = (wr > LIMIT) || (wr < -LIMIT);
    assign r   = wr[WIDTH-1:0];

endmodule

// File: rtl/calc_key_engine.sv
// calc_key_engine: click edge detector, key FSM, decimal operand
// accumulators and display outputs of the on-screen calculator.
//   CLK_100MHZ : system clock (rising edge)
//   reset      : synchronous active-high reset
//   bus        : calc_key_engine_if slave (click/key_idx in,
//                disp_val/disp_err/op_pend/key_ack out)
// Optional feature macro: CALC_MUL_EN enables key 12 (multiply); without it
// key 12 is an unused code.
module calc_key_engine
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 16
) (
    input  logic              CLK_100MHZ,
    input  logic              reset,
    calc_key_engine_if.slave  bus
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic signed [WIDTH-1:0] TEN = WIDTH'(10);

    logic                    click_q_reg;
    logic                    first_reg;
    logic [2:0]              state_reg, state_next;
    logic signed [WIDTH-1:0] a_reg, a_next;
    logic signed [WIDTH-1:0] b_reg, b_next;
    logic [1:0]              op_reg, op_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic                    ack_reg, ack_next;

    logic                    key_event;
    logic                    key_valid;
    logic                    key_is_op;
    logic                    key_is_dig;
    logic                    can_append;
    logic signed [WIDTH-1:0] digit_val;
    logic signed [WIDTH-1:0] acc_val;
    logic signed [WIDTH-1:0] alu_r;
    logic                    alu_ovf;

    // first_reg masks the first cycle out of reset, so a button already held
    // when reset releases only reloads click_q and needs a fresh rise.
    assign key_event = bus.click & ~click_q_reg & ~first_reg;

    always_comb begin
        key_valid = (bus.key_idx <= KEY_CLR);
`ifndef CALC_MUL_EN
        if (bus.key_idx == KEY_MUL) begin
            key_valid = 1'b0;
        end
`endif
    end

    assign key_is_dig = is_digit(bus.key_idx);
    assign key_is_op  = key_valid && (bus.key_idx >= KEY_ADD) && (bus.key_idx <= KEY_MUL);
    assign can_append = (cnt_reg < CW'(DIGITS));
    assign digit_val  = {{(WIDTH-5){1'b0}}, bus.key_idx};
    // Shared append path: whichever operand is currently being entered.
    assign acc_val    = ((state_reg == S_B) ? b_reg : a_reg) * TEN + digit_val;

    calc_alu #(.DIGITS(DIGITS), .WIDTH(WIDTH)) u_alu (
        .a   (a_reg),
        .b   (b_reg),
        .op  (op_reg),
        .r   (alu_r),
        .ovf (alu_ovf)
    );

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        cnt_next   = cnt_reg;
        ack_next   = 1'b0;
        if (key_event && key_valid) begin
            if (bus.key_idx == KEY_CLR) begin
                state_next = S_A;
                a_next     = '0;
                b_next     = '0;
                op_next    = OP_NONE;
                cnt_next   = '0;
                ack_next   = 1'b1;
            end else if (state_reg != S_ERR) begin
                // Every valid key outside the error state is acknowledged,
                // even when it leaves the operands unchanged.
                ack_next = 1'b1;
                case (state_reg)
                    S_A: begin
                        if (key_is_dig) begin
                            if (can_append) begin
                                a_next   = acc_val;
                                cnt_next = cnt_reg + CW'(1);
                            end
                        end else if (key_is_op) begin
                            op_next    = key_to_op(bus.key_idx);
                            state_next = S_OP;
                        end
                    end
                    S_OP: begin
                        if (key_is_op) begin
                            op_next = key_to_op(bus.key_idx);
                        end else if (key_is_dig) begin
                            b_next     = digit_val;
                            cnt_next   = CW'(1);
                            state_next = S_B;
                        end
                    end
                    S_B: begin
                        if (key_is_dig) begin
                            if (can_append) begin
                                b_next   = acc_val;
                                cnt_next = cnt_reg + CW'(1);
                            end
                        end else if (alu_ovf) begin
                            state_next = S_ERR;
                            a_next     = '0;
                            b_next     = '0;
                            op_next    = OP_NONE;
                        end else if (bus.key_idx == KEY_EQ) begin
                            a_next     = alu_r;
                            op_next    = OP_NONE;
                            state_next = S_RES;
                        end else begin
                            // Chaining: the result becomes A for the new operator.
                            a_next     = alu_r;
                            op_next    = key_to_op(bus.key_idx);
                            state_next = S_OP;
                        end
                    end
                    S_RES: begin
                        if (key_is_dig) begin
                            a_next     = digit_val;
                            cnt_next   = CW'(1);
                            state_next = S_A;
                        end else if (key_is_op) begin
                            op_next    = key_to_op(bus.key_idx);
                            state_next = S_OP;
                        end
                    end
                    default: state_next = S_A;
                endcase
            end
        end
    end

    always_ff @(posedge CLK_100MHZ) begin
        if (reset) begin
            click_q_reg <= 1'b0;
            first_reg   <= 1'b1;
            state_reg   <= S_A;
            a_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= OP_NONE;
            cnt_reg     <= '0;
            ack_reg     <= 1'b0;
        end else begin
            click_q_reg <= bus.click;
            first_reg   <= 1'b0;
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            op_reg      <= op_next;
            cnt_reg     <= cnt_next;
            ack_reg     <= ack_next;
        end
    end

    assign bus.disp_val = (state_reg == S_ERR) ? '0 :
                          (state_reg == S_B)   ? b_reg : a_reg;
    assign bus.disp_err = (state_reg == S_ERR);
    assign bus.op_pend  = ((state_reg == S_OP) || (state_reg == S_B)) ? op_reg : OP_NONE;
    assign bus.key_ack  = ack_reg;

endmodule

// File: tb/tb_calc_key_engine.sv
// tb_calc_key_engine: directed key sequences against a behavioural
// calculator model; outputs compared on every falling clock edge, plus
// hand-computed literal expectations at the end of each sequence.
module tb_calc_key_engine;

    localparam int M_A = 0, M_OP = 1, M_B = 2, M_RES = 3, M_ERR = 4;

    logic clk;
    logic reset;

    calc_key_engine_if #(.WIDTH(16)) bus ();

    calc_key_engine #(.DIGITS(4), .WIDTH(16)) dut (
        .CLK_100MHZ (clk),
        .reset      (reset),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int ack_seen = 0;
    bit chk_en   = 0;

    // model of the calculator
    int m_mode, m_a, m_b, m_op, m_cnt;
    int exp_val, exp_err, exp_op, exp_ack;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_outputs();
        exp_err = (m_mode == M_ERR) ? 1 : 0;
        exp_val = (m_mode == M_ERR) ? 0 : (m_mode == M_B) ? m_b : m_a;
        exp_op  = (m_mode == M_OP || m_mode == M_B) ? m_op : 0;
    endtask

    task automatic model_reset();
        m_mode = M_A; m_a = 0; m_b = 0; m_op = 0; m_cnt = 0;
        exp_ack = 0;
        model_outputs();
    endtask

    task automatic model_key(input int k);
        int r;
        bit valid, dig, opk;
        valid = (k >= 0 && k <= 14);
`ifndef CALC_MUL_EN
        if (k == 12) valid = 0;
`endif
        dig = (k <= 9);
        opk = (k >= 10 && k <= 12);
        exp_ack = 0;
        if (valid) begin
            if (k == 14) begin
                m_mode = M_A; m_a = 0; m_b = 0; m_op = 0; m_cnt = 0;
                exp_ack = 1;
            end else if (m_mode != M_ERR) begin
                exp_ack = 1;
                case (m_mode)
                    M_A: begin
                        if (dig) begin
                            if (m_cnt < 4) begin m_a = m_a * 10 + k; m_cnt++; end
                        end else if (opk) begin
                            m_op = k - 9; m_mode = M_OP;
                        end
                    end
                    M_OP: begin
                        if (opk) m_op = k - 9;
                        else if (dig) begin m_b = k; m_cnt = 1; m_mode = M_B; end
                    end
                    M_B: begin
                        if (dig) begin
                            if (m_cnt < 4) begin m_b = m_b * 10 + k; m_cnt++; end
                        end else begin
                            r = (m_op == 1) ? m_a + m_b : (m_op == 2) ? m_a - m_b : m_a * m_b;
                            if (r > 9999 || r < -9999) m_mode = M_ERR;
                            else begin
                                m_a = r;
                                if (k == 13) begin m_op = 0; m_mode = M_RES; end
                                else begin m_op = k - 9; m_mode = M_OP; end
                            end
                        end
                    end
                    default: begin
                        if (dig) begin m_a = k; m_cnt = 1; m_mode = M_A; end
                        else if (opk) begin m_op = k - 9; m_mode = M_OP; end
                    end
                endcase
            end
        end
        model_outputs();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("disp_val", int'(bus.disp_val), exp_val);
            chk("disp_err", int'(bus.disp_err), exp_err);
            chk("op_pend",  int'(bus.op_pend),  exp_op);
            chk("key_ack",  int'(bus.key_ack),  exp_ack);
            if (bus.key_ack) ack_seen++;
        end
    end

    // One key press: rise, hold for 'hold' extra cycles, release.
    task automatic press(input int k, input int hold);
        @(negedge clk);
        bus.click   = 1'b1;
        bus.key_idx = 5'(k);
        @(posedge clk); #1;
        model_key(k);
        @(posedge clk); #1;
        exp_ack = 0;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        bus.click = 1'b0;
        $display("key %0d -> val=%0d err=%0d op=%0d", k, exp_val, exp_err, exp_op);
    endtask

    task automatic keys(input int seq[$]);
        foreach (seq[i]) press(seq[i], 0);
        @(negedge clk); #1;
    endtask

    int acks0;

    initial begin
        bus.click = 1'b0;
        bus.key_idx = 5'd0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1;
        @(negedge clk); #1;
        chk("reset_val", int'(bus.disp_val), 0);
        chk("reset_ack", int'(bus.key_ack), 0);

        // 1 2 + 3 = -> 15, five acks
        acks0 = ack_seen;
        keys('{1, 2, 10, 3, 13});
        chk("sum_model", exp_val, 15);
        chk("sum_dut", int'(bus.disp_val), 15);
        chk("sum_acks", ack_seen - acks0, 5);

        // long hold on key 7 -> single event
        keys('{14});
        acks0 = ack_seen;
        press(7, 50);
        @(negedge clk); #1;
        chk("hold_val", int'(bus.disp_val), 7);
        chk("hold_acks", ack_seen - acks0, 1);

        // digit limit: fifth 9 acked, no change
        keys('{14});
        acks0 = ack_seen;
        keys('{9, 9, 9, 9, 9});
        chk("limit_val", int'(bus.disp_val), 9999);
        chk("limit_acks", ack_seen - acks0, 5);

        // chaining and negative results
        keys('{14});
`ifdef CALC_MUL_EN
        keys('{3, 11, 8, 12});
        chk("chain_mid", int'(bus.disp_val), -5);
        chk("chain_op", int'(bus.op_pend), 3);
        keys('{2, 13});
        chk("chain_model", exp_val, -10);
        chk("chain_dut", int'(bus.disp_val), -10);
        keys('{11, 5, 13});
        chk("neg_chain", int'(bus.disp_val), -15);
`else
        keys('{3, 11, 8, 10});
        chk("chain_mid", int'(bus.disp_val), -5);
        chk("chain_op", int'(bus.op_pend), 1);
        keys('{2, 13});
        chk("chain_model", exp_val, -3);
        chk("chain_dut", int'(bus.disp_val), -3);
        keys('{11, 5, 13});
        chk("neg_chain", int'(bus.disp_val), -8);
`endif

        // unused key code
        acks0 = ack_seen;
        keys('{20});
        chk("unused_acks", ack_seen - acks0, 0);

        // overflow -> error, keys ignored, C recovers
        keys('{14});
`ifdef CALC_MUL_EN
        keys('{9, 9, 9, 9, 12, 2, 13});
`else
        keys('{9, 9, 9, 9, 10, 1, 13});
`endif
        chk("ovf_err", int'(bus.disp_err), 1);
        chk("ovf_val", int'(bus.disp_val), 0);
        acks0 = ack_seen;
        keys('{5});
        chk("err_ignore_acks", ack_seen - acks0, 0);
        keys('{14});
        chk("clr_err", int'(bus.disp_err), 0);
        chk("clr_val", int'(bus.disp_val), 0);

`ifndef CALC_MUL_EN
        // multiply key unavailable
        acks0 = ack_seen;
        keys('{4, 12, 2});
        chk("nomul_val", int'(bus.disp_val), 42);
        chk("nomul_op", int'(bus.op_pend), 0);
        chk("nomul_acks", ack_seen - acks0, 2);
`endif

        // click rising during reset and held across deassertion: no event
        @(negedge clk);
        chk_en = 0;
        reset = 1'b1;
        bus.click = 1'b1;
        bus.key_idx = 5'd7;
        repeat (3) @(negedge clk);
        model_reset();
        reset = 1'b0;
        chk_en = 1;
        acks0 = ack_seen;
        repeat (5) @(negedge clk);
        #1;
        chk("rst_held_acks", ack_seen - acks0, 0);
        chk("rst_held_val", int'(bus.disp_val), 0);
        @(negedge clk);
        bus.click = 1'b0;
        keys('{5});
        chk("post_rst_val", int'(bus.disp_val), 5);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/calc_key_engine.md
# calc_key_engine

Key-entry and arithmetic engine of the on-screen calculator. Consumes the left-button level and the 5-bit key index from the clicked-square decoder, detects click events, and accumulates decimal operands. Executes + / − / × on `=` or on operator chaining and drives the signed value and error flag shown by the VGA painter. Sits directly downstream of the clicked-square decoder on the 100 MHz clock.

## Interface
- `DIGITS`, 4: maximum decimal digits per operand. Requires 10^DIGITS−1 < 2^(WIDTH−1).
- `WIDTH`, 16: signed two's-complement width of operands and result.
- `CLK_100MHZ`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `click`  in  1  left-button level (btn[0]), same clock domain.
- `key_idx`  in  5  key under the cursor from the clicked-square decoder. Valid whenever `click` is high.
- `disp_val`  out  WIDTH  signed value to display.
- `disp_err`  out  1  error indicator (overflow).
- `op_pend`  out  2  pending operator: 0 none, 1 add, 2 sub, 3 mul.
- `key_ack`  out  1  one-cycle pulse when a key event is accepted (not ignored).

## Operation
- Key codes: 0–9 digits, 10 `+`, 11 `−`, 12 `×`, 13 `=`, 14 `C`. Codes 15–31 are ignored (no `key_ack`).
- Event: `click` high while the registered `click_q` is low. `key_idx` is sampled in that cycle. Holding the button produces exactly one event.
- State `S_A` (reset state): entering A.
  - Digit: A ← A·10+d if the digit count < DIGITS, else ignored.
  - Operator: latch op, go to `S_OP`.
  - `=`: ignored.
- State `S_OP`: operator chosen.
  - Operator: replaces op.
  - Digit: B ← d, go to `S_B`.
  - `=`: ignored.
- State `S_B`: entering B, same digit rule as A.
  - `=`: R ← A op B, A ← R, go to `S_RES`.
  - Operator: evaluate R the same way, A ← R, latch new op, go to `S_OP` (chaining).
- State `S_RES`: result shown.
  - Digit: A ← d with the count reset, go to `S_A`.
  - Operator: keep A = R, go to `S_OP`.
  - `=`: ignored.
- State `S_ERR`: all keys except `C` are ignored.
- `C` in any state clears A, B, op and counts, goes to `S_A`, and pulses `key_ack`.
- Arithmetic is done at 2·WIDTH signed. Any |R| > 10^DIGITS−1 goes to `S_ERR` with `disp_err`=1 and `disp_val`=0.
- Negative results are allowed. A negative A may be chained.
- `disp_val`:
  - A in `S_A`, `S_OP` and `S_RES`.
  - B in `S_B`.
- `op_pend` is non-zero in `S_OP` and `S_B` only.

## Timing
- Reset values: `disp_val`=0, `disp_err`=0, `op_pend`=0, `key_ack`=0, state `S_A`, `click_q`=0.
- Latency: for an edge sampled in cycle n, state, registers and outputs are updated at edge n+1. `key_ack` is high during cycle n+1 only.
- One event is possible at most every 2 cycles (click must drop and rise again). No back-pressure.
- Reset asserted together with an event: reset wins, and the event is lost.
- `click` already high when reset deasserts: no event, because `click_q` reloads from `click` in the first cycle out of reset. An event needs a new rise.

## Configuration
- `CALC_MUL_EN` defined: key 12 selects multiply, and the 2·WIDTH product path is instantiated.
- `CALC_MUL_EN` undefined:
  - Key 12 is treated as an unused code (ignored, no `key_ack`).
  - `op_pend` never equals 3.
  - No multiplier is synthesized.

## Structure
- Package `calc_pkg` holds:
  - key-code localparams (`KEY_ADD`, `KEY_SUB`, `KEY_MUL`, `KEY_EQ`, `KEY_CLR`);
  - state encoding `S_A`, `S_OP`, `S_B`, `S_RES`, `S_ERR`;
  - operator encoding 0–3.
- Sub-module `calc_alu`: combinational A, B, op → R and overflow flag. Contains the multiply path under `CALC_MUL_EN`.
- Top-level `calc_key_engine` contains the edge detector, FSM, digit accumulators and output registers.

## Test plan
- Reset, then click keys 1, 2, `+`, 3, `=` → `disp_val`=15, `op_pend`=0, five `key_ack` pulses.
- Click `click` high for 50 cycles on key 7 → A=7 (single event), `key_ack` high exactly one cycle.
- Keys 9,9,9,9,9 → A=9999. The fifth digit gets no change and still `key_ack`.
- Keys 3, `−`, 8, `×`, 2, `=` → chained result: −5 after `×`, then `disp_val`=−10.
- Keys 9,9,9,9, `×`, 2, `=` → `disp_err`=1, `disp_val`=0. Then key 5 is ignored. Then `C` → `disp_err`=0, `disp_val`=0.
- Build without `CALC_MUL_EN`: keys 4, key 12, 2 → A=42, `op_pend`=0, no `key_ack` for key 12.
